// File: rtl/cmp_pipe.sv
// Two-stage compare/min/max pipeline with valid/ready handshake on both sides.
// Also provides N/Z/C/V flags of A-B, a less-than bit and a saturating equal-match counter.
module cmp_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [1:0]       mode,
   input  logic             sgn,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Result,
   output logic [3:0]       Flag,
   output logic             S,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] eq_count
);

   localparam int unsigned DW = WIDTH + 1;
   localparam logic [1:0] MODE_MIN = 2'b01;
   localparam logic [1:0] MODE_MAX = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [1:0]       mode;
      logic             sgn;
      logic [DW-1:0]    d;
   } s1_t;

   logic             v1;
   s1_t              s1_q;

   logic             adv2_c;
   logic             load1_c;
   logic             accept_c;
   logic             deliver_c;
   logic [DW-1:0]    diff_c;

   logic             n_c;
   logic             z_c;
   logic             c_c;
   logic             v_c;
   logic             s_c;
   logic [WIDTH-1:0] res_c;

   // Handshake: S2 frees up when empty or delivering; S1 frees up when empty or advancing.
   always_comb begin
      adv2_c    = !out_valid || out_ready;
      load1_c   = !v1 || adv2_c;
      accept_c  = in_valid && load1_c;
      deliver_c = out_valid && out_ready;
   end

   assign in_ready = load1_c;

   // Zero-extended subtraction: the top bit is the unsigned borrow.
   always_comb begin
      diff_c = {1'b0, in1} - {1'b0, in2};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         s1_q <= '0;
      end else if (load1_c) begin
         v1 <= in_valid;
         if (in_valid) begin
            s1_q.a    <= in1;
            s1_q.b    <= in2;
            s1_q.mode <= mode;
            s1_q.sgn  <= sgn;
            s1_q.d    <= diff_c;
         end
      end
   end

   // Flags, less-than and result selection from the captured difference.
   always_comb begin
      n_c   = s1_q.d[WIDTH-1];
      z_c   = (s1_q.a == s1_q.b);
      c_c   = !s1_q.d[WIDTH];
      v_c   = (s1_q.a[WIDTH-1] ^ s1_q.b[WIDTH-1]) & (n_c ^ s1_q.a[WIDTH-1]);
      s_c   = s1_q.sgn ? (n_c ^ v_c) : !c_c;
      res_c = s1_q.d[WIDTH-1:0];
      case (s1_q.mode)
         MODE_MIN: res_c = s_c ? s1_q.a : s1_q.b;
         MODE_MAX: res_c = s_c ? s1_q.b : s1_q.a;
         default:  res_c = s1_q.d[WIDTH-1:0];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         Result    <= '0;
         Flag      <= 4'b0000;
         S         <= 1'b0;
      end else if (adv2_c) begin
         out_valid <= v1;
         if (v1) begin
            Result <= res_c;
            Flag   <= {n_c, z_c, c_c, v_c};
            S      <= s_c;
         end
      end
   end

   // Saturating count of delivered equal compares; clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eq_count <= '0;
      end else if (clr_cnt) begin
         eq_count <= '0;
      end else if (deliver_c && Flag[2] && (eq_count != CNT_MAX)) begin
         eq_count <= eq_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cmp_pipe.sv
// Bench for cmp_pipe: spec-level model with per-cycle compare plus directed literal checks.
module tb_cmp_pipe;
   localparam int unsigned W  = 32;
   localparam int unsigned CW = 8;
   localparam logic [1:0] M_CMP = 2'b00;
   localparam logic [1:0] M_MIN = 2'b01;
   localparam logic [1:0] M_MAX = 2'b10;
   localparam logic [1:0] M_RSV = 2'b11;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  in1, in2;
   logic [1:0]    mode;
   logic          sgn, in_valid, in_ready;
   logic [W-1:0]  Result;
   logic [3:0]    Flag;
   logic          S, out_valid, out_ready, clr_cnt;
   logic [CW-1:0] eq_count;

   always #5 clk = ~clk;

   cmp_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .mode(mode), .sgn(sgn),
      .in_valid(in_valid), .in_ready(in_ready), .Result(Result), .Flag(Flag), .S(S),
      .out_valid(out_valid), .out_ready(out_ready), .clr_cnt(clr_cnt), .eq_count(eq_count)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   flg;
      logic         s;
      int           acc;
   } exp_t;

   exp_t          q[$];
   int            cyc = 0;
   logic [CW-1:0] mcnt = '0;
   int            n_deliv = 0;
   bit            saw_nr = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outcome straight from the arithmetic definitions.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [1:0] m, input logic sg, input int acc);
      exp_t e;
      longint sd;
      logic lt;
      logic [W-1:0] d;
      sd = longint'($signed(a)) - longint'($signed(b));
      lt = sg ? ($signed(a) < $signed(b)) : (a < b);
      d  = a - b;
      e.flg = {d[W-1], a == b, a >= b, (sd > SMAX) || (sd < SMIN)};
      e.s   = lt;
      case (m)
         M_MIN:   e.res = lt ? a : b;
         M_MAX:   e.res = lt ? b : a;
         default: e.res = d;
      endcase
      e.acc = acc;
      return e;
   endfunction

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      bit   ev;
      bit   rdy;
      exp_t h;
      cyc++;
      if (!rst_n) begin
         q.delete();
         mcnt = '0;
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_eq_count", 64'(eq_count), 64'd0);
      end else begin
         ev  = (q.size() > 0) && (cyc - q[0].acc >= 2);
         rdy = (q.size() < 2) || out_ready;
         chk("in_ready", 64'(in_ready), 64'(rdy));
         chk("out_valid", 64'(out_valid), 64'(ev));
         chk("eq_count", 64'(eq_count), 64'(mcnt));
         if (!in_ready) saw_nr = 1'b1;
         if (out_valid && out_ready) n_deliv++;
         if (ev) begin
            h = q[0];
            chk("result", 64'(Result), 64'(h.res));
            chk("flag", 64'(Flag), 64'(h.flg));
            chk("s", 64'(S), 64'(h.s));
         end
         if (clr_cnt) mcnt = '0;
         else if (ev && out_ready && h.flg[2] && mcnt != '1) mcnt = mcnt + CW'(1);
         if (ev && out_ready) void'(q.pop_front());
         if (in_valid && rdy) q.push_back(model(in1, in2, mode, sgn, cyc));
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] m, input logic sg);
      bit ok;
      ok = 1'b0;
      in1 = a; in2 = b; mode = m; sgn = sg; in_valid = 1'b1;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      chk("accept", 64'(ok), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic op_lit(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] m, input logic sg,
                         input logic [W-1:0] er, input logic [3:0] ef, input logic es);
      send(a, b, m, sg);
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_res"}, 64'(Result), 64'(er));
      chk({nm, "_flag"}, 64'(Flag), 64'(ef));
      chk({nm, "_s"}, 64'(S), 64'(es));
      @(posedge clk); #1;
   endtask

   logic [W-1:0] sa [6] = '{32'h0000_0064, 32'hFFFF_FF00, 32'h8000_0000,
                            32'h1234_5678, 32'h0000_0000, 32'hDEAD_BEEF};
   logic [W-1:0] sb [6] = '{32'h0000_0007, 32'h0000_0010, 32'h7FFF_FFFF,
                            32'h1234_5679, 32'hFFFF_FFFF, 32'h0BAD_F00D};
   logic [1:0]   sm [6] = '{M_CMP, M_MIN, M_CMP, M_MAX, M_MAX, M_MIN};
   logic         ss [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      int d0;
      rst_n = 1'b0; in1 = '0; in2 = '0; mode = M_CMP; sgn = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_result", 64'(Result), 64'd0);
      chk("reset_flag", 64'(Flag), 64'd0);
      chk("reset_s", 64'(S), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      op_lit("cmp_u_2_3", 32'd2, 32'd3, M_CMP, 1'b0, 32'hFFFF_FFFF, 4'b1000, 1'b1);
      op_lit("cmp_s_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, M_CMP, 1'b1, 32'h8000_0000, 4'b1001, 1'b0);
      op_lit("cmp_u_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, M_CMP, 1'b0, 32'h8000_0000, 4'b1001, 1'b1);
      op_lit("min_s", 32'd6, 32'hFFFF_FFFE, M_MIN, 1'b1, 32'hFFFF_FFFE, 4'b0000, 1'b0);
      op_lit("max_s", 32'd6, 32'hFFFF_FFFE, M_MAX, 1'b1, 32'd6, 4'b0000, 1'b0);
      op_lit("min_u", 32'd6, 32'hFFFF_FFFE, M_MIN, 1'b0, 32'd6, 4'b0000, 1'b1);
      op_lit("max_u", 32'd6, 32'hFFFF_FFFE, M_MAX, 1'b0, 32'hFFFF_FFFE, 4'b0000, 1'b1);
      op_lit("min_eq", 32'd10, 32'd10, M_MIN, 1'b1, 32'd10, 4'b0110, 1'b0);
      @(negedge clk);
      chk("eq_count_one", 64'(eq_count), 64'd1);
      @(posedge clk); #1;
      op_lit("rsv_cmp", 32'd5, 32'd3, M_RSV, 1'b0, 32'd2, 4'b0010, 1'b0);

      // Idle inputs wiggling with in_valid low must not produce anything.
      for (int i = 0; i < 5; i++) begin
         in1 = $urandom; in2 = $urandom; mode = 2'($urandom_range(0, 3)); sgn = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end

      // Back-to-back stream with a downstream stall.
      saw_nr = 1'b0;
      d0 = n_deliv;
      fork
         begin
            for (int i = 0; i < 6; i++) send(sa[i], sb[i], sm[i], ss[i]);
         end
         begin
            for (int c = 0; c < 8; c++) begin
               out_ready = !(c >= 3 && c <= 5);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk); #1;
      chk("stall_not_ready", 64'(saw_nr), 64'd1);
      chk("stream_deliv", 64'(n_deliv - d0), 64'd6);

      // Saturation of the equal counter.
      for (int i = 0; i < 260; i++) send(W'(i), W'(i), M_CMP, 1'b0);
      repeat (4) @(negedge clk);
      chk("eq_saturate", 64'(eq_count), 64'd255);
      @(posedge clk); #1;

      // Clear coinciding with an equal delivery.
      send(32'h55, 32'h55, M_CMP, 1'b1);
      @(posedge clk); #1;
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      @(negedge clk);
      chk("clr_priority", 64'(eq_count), 64'd0);
      @(posedge clk); #1;
      send(32'd7, 32'd7, M_MAX, 1'b0);
      repeat (3) @(posedge clk); #1;

      // Reset with both stages full.
      out_ready = 1'b0;
      send(32'd1, 32'd2, M_CMP, 1'b0);
      send(32'd3, 32'd4, M_CMP, 1'b1);
      @(negedge clk);
      chk("full_out_valid", 64'(out_valid), 64'd1);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_eq_count", 64'(eq_count), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_imm_valid", 64'(out_valid), 64'd0);
      chk("rst_imm_count", 64'(eq_count), 64'd0);
      chk("rst_imm_result", 64'(Result), 64'd0);
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      d0 = n_deliv;
      @(negedge clk);
      chk("ready_after_rst2", 64'(in_ready), 64'd1);
      repeat (10) @(negedge clk);
      chk("no_output_after_rst", 64'(n_deliv - d0), 64'd0);
      chk("model_empty", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
